hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Generates the 2-bit IF_ID_Signal consumed by the IF/ID pipeline register: 0 = normal load, 1 = stall (hold), 2 = flush (zero).
- Also drives PC write-enable and the ID/EX bubble insert.
- Detects load-use hazards, taken branches/jumps and multi-cycle execute operations such as mult/div.
- Sits in the ID stage beside the register file.

Parameters:
- MC_LATENCY, 4, total cycles a multi-cycle op occupies EX; legal range 2..15.
- FLUSH_CYCLES, 1, cycles IF/ID is held flushed after a taken branch; legal range 1..3.

Ports:
- Clock  in  1  pipeline clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- IF_ID_Rs  in  5  rs field of the instruction in IF/ID.
- IF_ID_Rt  in  5  rt field of the instruction in IF/ID.
- ID_EX_MemRead  in  1  instruction in ID/EX is a load.
- ID_EX_Rt  in  5  destination of the load in ID/EX.
- MultiCycleStart  in  1  ID/EX holds a multi-cycle op entering EX this cycle.
- BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- IF_ID_Signal  out  2  0 load, 1 stall, 2 flush; 3 is never driven.
- PCWrite  out  1  1 = PC may update.
- ID_EX_Bubble  out  1  1 = ID/EX loads all-zero control (NOP).
- HazardState  out  2  current FSM state for debug: 0 RUN, 1 MC_STALL, 2 FLUSH.

Behaviour:
- FSM and counter are registered. Outputs are combinational from the registered state plus current inputs, so they are valid before the posedge at which the IF/ID register samples them.
- Reset (Reset=1 at posedge):
  - state <= RUN; counter <= 0.
  - While Reset is high, outputs are forced to IF_ID_Signal=2, PCWrite=0, ID_EX_Bubble=1, HazardState=0, regardless of state.
- Load-use condition LU = ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || ID_EX_Rt==IF_ID_Rt).
- RUN state, evaluated in priority order:
  - BranchTaken: IF_ID_Signal=2, PCWrite=1, ID_EX_Bubble=1. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - MultiCycleStart: IF_ID_Signal=1, PCWrite=0, ID_EX_Bubble=1. Go to MC_STALL with counter=MC_LATENCY-2.
  - LU: IF_ID_Signal=1, PCWrite=0, ID_EX_Bubble=1. Stay in RUN; the stall lasts exactly one cycle because the load advances.
  - Otherwise: IF_ID_Signal=0, PCWrite=1, ID_EX_Bubble=0.
- MC_STALL state:
  - IF_ID_Signal=1, PCWrite=0, ID_EX_Bubble=1 every cycle.
  - Counter decrements each cycle. When counter==0, go to RUN.
  - Total stall from the start cycle = MC_LATENCY-1 cycles.
  - BranchTaken here has priority: outputs become flush values (2,1,1), counter is cleared, and the state goes to FLUSH or RUN per the FLUSH_CYCLES rule.
  - MultiCycleStart and LU are ignored in this state.
- FLUSH state:
  - IF_ID_Signal=2, PCWrite=1, ID_EX_Bubble=1. Counter decrements; go to RUN when counter==0.
  - A new BranchTaken reloads counter=FLUSH_CYCLES-1.
  - MultiCycleStart and LU are ignored, since those instructions are being squashed.
- Simultaneous BranchTaken + LU + MultiCycleStart in RUN: flush wins and the stall is dropped.
- Counter width is 4 bits and never wraps: decrement happens only when nonzero.
- Reset asserted mid-MC_STALL or mid-FLUSH aborts to RUN at that posedge.
- IF_ID_Signal value 3 must never appear. The bench asserts this every cycle.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> during reset outputs are (2,0,1); after the first posedge with Reset=0, outputs are (0,1,0) and HazardState=0.
- ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 for one cycle, then MemRead=0 -> exactly one cycle of (1,0,1), then (0,1,0). Repeat with ID_EX_Rt=0 -> no stall.
- MultiCycleStart=1 for one cycle with MC_LATENCY=4 -> (1,0,1) for exactly 3 consecutive cycles, HazardState 0→1→1→0, then (0,1,0).
- BranchTaken=1 together with LU true and MultiCycleStart=1 -> (2,1,1) that cycle; no MC_STALL entry; next cycle (0,1,0).
- FLUSH_CYCLES=3, BranchTaken pulse -> flush for 3 cycles; a second BranchTaken in cycle 2 extends flush to cycle 4. BranchTaken on the 2nd MC_STALL cycle -> immediate flush with the stall aborted.
- Reset asserted during the 2nd MC_STALL cycle -> state RUN and counter 0 at that posedge; with inputs idle after release, no residual stall.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Hazard unit signal bundle between the ID-stage pipeline logic and the hazard control unit.
interface hazard_control_unit_if;
  localparam int unsigned REG_W = 5;

  logic [REG_W-1:0] IF_ID_Rs;
  logic [REG_W-1:0] IF_ID_Rt;
  logic             ID_EX_MemRead;
  logic [REG_W-1:0] ID_EX_Rt;
  logic             MultiCycleStart;
  logic             BranchTaken;
  logic [1:0]       IF_ID_Signal;
  logic             PCWrite;
  logic             ID_EX_Bubble;
  logic [1:0]       HazardState;

  // Pipeline side: supplies instruction fields, consumes the control decisions
  modport master (
    output IF_ID_Rs, IF_ID_Rt, ID_EX_MemRead, ID_EX_Rt, MultiCycleStart, BranchTaken,
    input  IF_ID_Signal, PCWrite, ID_EX_Bubble, HazardState
  );

  // Hazard unit side
  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, ID_EX_MemRead, ID_EX_Rt, MultiCycleStart, BranchTaken,
    output IF_ID_Signal, PCWrite, ID_EX_Bubble, HazardState
  );
endinterface

// File: rtl/hazard_control_unit.sv
// ID-stage hazard control: load-use stalls, multi-cycle EX stalls and branch flushes.
// Outputs are combinational from registered state plus current inputs so they settle
// ahead of the edge at which IF/ID and ID/EX sample them.
module hazard_control_unit #(
  parameter int unsigned MC_LATENCY   = 4,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  hazard_control_unit_if.slave  hz
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MC_LOAD    = CNT_W'(MC_LATENCY - 2);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] SIG_LOAD  = 2'd0;
  localparam logic [1:0] SIG_STALL = 2'd1;
  localparam logic [1:0] SIG_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load_use_c;

  // Load in EX writes a register the instruction in ID reads; $zero never hazards
  assign load_use_c = hz.ID_EX_MemRead && (hz.ID_EX_Rt != '0) &&
                      ((hz.ID_EX_Rt == hz.IF_ID_Rs) || (hz.ID_EX_Rt == hz.IF_ID_Rt));

  // State and counter register; reset aborts any stall or flush in progress
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and output decode; the counter holds the cycles left after the current one
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    hz.IF_ID_Signal = SIG_LOAD;
    hz.PCWrite      = 1'b1;
    hz.ID_EX_Bubble = 1'b0;
    hz.HazardState  = state_q;

    unique case (state_q)
      RUN: begin
        if (hz.BranchTaken) begin
          hz.IF_ID_Signal = SIG_FLUSH;
          hz.ID_EX_Bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            count_d = FLUSH_LOAD;
          end else begin
            count_d = '0;
          end
        end else if (hz.MultiCycleStart) begin
          hz.IF_ID_Signal = SIG_STALL;
          hz.PCWrite      = 1'b0;
          hz.ID_EX_Bubble = 1'b1;
          // A two-cycle op is covered entirely by this start cycle
          if (MC_LATENCY > 2) begin
            state_d = MC_STALL;
            count_d = MC_LOAD;
          end
        end else if (load_use_c) begin
          hz.IF_ID_Signal = SIG_STALL;
          hz.PCWrite      = 1'b0;
          hz.ID_EX_Bubble = 1'b1;
        end
      end

      MC_STALL: begin
        if (hz.BranchTaken) begin
          hz.IF_ID_Signal = SIG_FLUSH;
          hz.ID_EX_Bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            count_d = FLUSH_LOAD;
          end else begin
            state_d = RUN;
            count_d = '0;
          end
        end else begin
          hz.IF_ID_Signal = SIG_STALL;
          hz.PCWrite      = 1'b0;
          hz.ID_EX_Bubble = 1'b1;
          if (count_q <= CNT_ONE) begin
            state_d = RUN;
            count_d = '0;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
      end

      FLUSH: begin
        hz.IF_ID_Signal = SIG_FLUSH;
        hz.ID_EX_Bubble = 1'b1;
        if (hz.BranchTaken) begin
          count_d = FLUSH_LOAD;
        end else if (count_q <= CNT_ONE) begin
          state_d = RUN;
          count_d = '0;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end

      default: begin
        state_d = RUN;
        count_d = '0;
      end
    endcase

    // Reset squashes the pipeline front end regardless of state
    if (Reset) begin
      hz.IF_ID_Signal = SIG_FLUSH;
      hz.PCWrite      = 1'b0;
      hz.ID_EX_Bubble = 1'b1;
      hz.HazardState  = RUN;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: two hazard units (default and long-flush parameters) driven by
// directed and random stimulus, compared every cycle against a remaining-cycles model.
module tb_hazard_control_unit;
  logic       Clock;
  logic       rst;
  logic [4:0] rs, rt, ex_rt;
  logic       mem_rd, mc_start, br_taken;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model parameters and state per DUT: 0 = defaults, 1 = long flush / longer op
  int unsigned ml [2] = '{4, 5};
  int unsigned fc [2] = '{1, 3};
  int unsigned stall_left [2] = '{0, 0};
  int unsigned flush_left [2] = '{0, 0};

  hazard_control_unit_if hz_a ();
  hazard_control_unit_if hz_b ();

  assign hz_a.IF_ID_Rs        = rs;
  assign hz_a.IF_ID_Rt        = rt;
  assign hz_a.ID_EX_MemRead   = mem_rd;
  assign hz_a.ID_EX_Rt        = ex_rt;
  assign hz_a.MultiCycleStart = mc_start;
  assign hz_a.BranchTaken     = br_taken;
  assign hz_b.IF_ID_Rs        = rs;
  assign hz_b.IF_ID_Rt        = rt;
  assign hz_b.ID_EX_MemRead   = mem_rd;
  assign hz_b.ID_EX_Rt        = ex_rt;
  assign hz_b.MultiCycleStart = mc_start;
  assign hz_b.BranchTaken     = br_taken;

  hazard_control_unit dut_a (
    .Clock (Clock),
    .Reset (rst),
    .hz    (hz_a)
  );

  hazard_control_unit #(.MC_LATENCY(5), .FLUSH_CYCLES(3)) dut_b (
    .Clock (Clock),
    .Reset (rst),
    .hz    (hz_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Apply one cycle of inputs, compare both DUTs to the model, then advance the model
  task automatic step(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input logic mr, input logic [4:0] xrt, input logic m, input logic b);
    int unsigned ns [2];
    int unsigned nf [2];
    logic lu;
    @(negedge Clock);
    rst = r; rs = a_rs; rt = a_rt; mem_rd = mr; ex_rt = xrt; mc_start = m; br_taken = b;
    #1;
    lu = mr && (xrt != 0) && (xrt == a_rs || xrt == a_rt);
    for (int k = 0; k < 2; k++) begin
      int unsigned e_sig, e_pc, e_bub, e_hs;
      int unsigned a_sig, a_pc, a_bub, a_hs;
      ns[k] = stall_left[k];
      nf[k] = flush_left[k];
      e_sig = 0; e_pc = 1; e_bub = 0; e_hs = 0;
      if (r) begin
        e_sig = 2; e_pc = 0; e_bub = 1; e_hs = 0;
        ns[k] = 0; nf[k] = 0;
      end else if (flush_left[k] > 0) begin
        e_sig = 2; e_pc = 1; e_bub = 1; e_hs = 2;
        nf[k] = b ? fc[k] - 1 : flush_left[k] - 1;
      end else if (stall_left[k] > 0) begin
        e_hs = 1;
        if (b) begin
          e_sig = 2; e_pc = 1; e_bub = 1;
          ns[k] = 0; nf[k] = fc[k] - 1;
        end else begin
          e_sig = 1; e_pc = 0; e_bub = 1;
          ns[k] = stall_left[k] - 1;
        end
      end else begin
        if (b) begin
          e_sig = 2; e_pc = 1; e_bub = 1;
          nf[k] = fc[k] - 1;
        end else if (m) begin
          e_sig = 1; e_pc = 0; e_bub = 1;
          ns[k] = ml[k] - 2;
        end else if (lu) begin
          e_sig = 1; e_pc = 0; e_bub = 1;
        end
      end
      if (k == 0) begin
        a_sig = hz_a.IF_ID_Signal; a_pc = hz_a.PCWrite;
        a_bub = hz_a.ID_EX_Bubble; a_hs = hz_a.HazardState;
      end else begin
        a_sig = hz_b.IF_ID_Signal; a_pc = hz_b.PCWrite;
        a_bub = hz_b.ID_EX_Bubble; a_hs = hz_b.HazardState;
      end
      check($sformatf("dut%0d.sig_not3", k), (a_sig == 3) ? 1 : 0, 0);
      check($sformatf("dut%0d.IF_ID_Signal", k), a_sig, e_sig);
      check($sformatf("dut%0d.PCWrite", k), a_pc, e_pc);
      check($sformatf("dut%0d.ID_EX_Bubble", k), a_bub, e_bub);
      check($sformatf("dut%0d.HazardState", k), a_hs, e_hs);
    end
    @(posedge Clock);
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = ns[k];
      flush_left[k] = nf[k];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rs = '0; rt = '0; mem_rd = 1'b0; ex_rt = '0; mc_start = 1'b0; br_taken = 1'b0;

    // Reset held two cycles, then release idle
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(2);

    // Load-use on rs, then $zero destination (no hazard), then match on rt
    step(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
    idle(1);

    // Multi-cycle op pulse
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(6);

    // Branch together with load-use and multi-cycle start: flush wins
    step(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1);
    idle(5);

    // Branch, then a second branch in the second flush cycle
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(5);

    // Branch during the multi-cycle stall, at two different points
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(5);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(5);

    // Reset during the stall and during a flush, with stray requests held high
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    idle(4);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(4);

    // Random traffic with small register indices to provoke frequent matches
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
